// File: rtl/relu_stream_unit_pkg.sv
// Shared constants for the multi-lane ReLU activation stream.
// Mode encodings and half-precision field geometry.
package relu_stream_unit_pkg;

  localparam logic [1:0] MODE_RELU   = 2'b00;
  localparam logic [1:0] MODE_LEAKY  = 2'b01;
  localparam logic [1:0] MODE_CLAMP  = 2'b10;
  localparam logic [1:0] MODE_BYPASS = 2'b11;

  localparam int HP_WIDTH = 16;
  localparam int HP_EXP_W = 5;
  localparam int HP_MAN_W = HP_WIDTH - 1 - HP_EXP_W;

  localparam logic [HP_WIDTH-1:0] HP_NEG_ZERO = 16'h8000;
  localparam logic [HP_WIDTH-1:0] HP_POS_INF  = 16'h7C00;

endpackage

// File: rtl/relu_lane_fn.sv
// Combinational per-lane activation: relu, leaky, clamp, bypass.
// Class flags arrive pre-registered from stage 1.
module relu_lane_fn
  import relu_stream_unit_pkg::*;
#(
  parameter int WIDTH      = HP_WIDTH,
  parameter int EXP_W      = HP_EXP_W,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cap,
  input  logic             neg,
  input  logic             nan,
  input  logic             inf,
  input  logic             zexp,
  output logic [WIDTH-1:0] y
);

  localparam int MAN_W = WIDTH - 1 - EXP_W;

  logic [EXP_W-1:0] e;
  logic [EXP_W-1:0] le;
  logic             leak_ok;
  logic [WIDTH-1:0] nzero;
  logic [WIDTH-2:0] ceil;
  logic [WIDTH-1:0] relu_y;
  logic [WIDTH-1:0] leaky_y;
  logic [WIDTH-1:0] clamp_y;

  assign e       = x[WIDTH-2 -: EXP_W];
  assign le      = e - EXP_W'(LEAK_SHIFT);
  assign leak_ok = (e > EXP_W'(LEAK_SHIFT)) && !zexp;
  assign nzero   = {1'b1, {(WIDTH-1){1'b0}}};
  // A negative ceiling collapses to +0
  assign ceil    = cap[WIDTH-1] ? '0 : cap[WIDTH-2:0];
  assign relu_y  = neg ? nzero : x;

  always_comb begin
    leaky_y = x;
    if (neg && !inf) begin
      leaky_y = leak_ok ? {1'b1, le, x[MAN_W-1:0]} : nzero;
    end
  end

  always_comb begin
    clamp_y = relu_y;
    if (neg) begin
      clamp_y = cap[WIDTH-1] ? '0 : nzero;
    end else if (inf || (x[WIDTH-2:0] > ceil)) begin
      clamp_y = {1'b0, ceil};
    end
  end

  always_comb begin
    y = x;
    if (!nan) begin
      unique case (1'b1)
        (mode == MODE_RELU):   y = relu_y;
        (mode == MODE_LEAKY):  y = leaky_y;
        (mode == MODE_CLAMP):  y = clamp_y;
        (mode == MODE_BYPASS): y = x;
        default:               y = x;
      endcase
    end
  end

endmodule

// File: rtl/relu_stream_unit.sv
// Two-stage multi-lane activation stream with valid/ready flow control
// and a saturating negative-lane statistics counter.
module relu_stream_unit
  import relu_stream_unit_pkg::*;
#(
  parameter int WIDTH      = HP_WIDTH,
  parameter int EXP_W      = HP_EXP_W,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             in_mode,
  input  logic [WIDTH-1:0]       in_cap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   stat_clear,
  output logic [CNT_W-1:0]       stat_neg_count
);

  localparam int MAN_W = WIDTH - 1 - EXP_W;
  localparam int PC_W  = $clog2(LANES + 1);

  logic                   s1_valid;
  logic                   s2_valid;
  logic                   s1_en;
  logic                   s2_en;
  logic                   in_fire;
  logic [LANES*WIDTH-1:0] s1_data;
  logic [1:0]             s1_mode;
  logic [WIDTH-1:0]       s1_cap;
  logic [LANES-1:0]       s1_neg;
  logic [LANES-1:0]       s1_nan;
  logic [LANES-1:0]       s1_inf;
  logic [LANES-1:0]       s1_zexp;
  logic [LANES-1:0]       c_neg;
  logic [LANES-1:0]       c_nan;
  logic [LANES-1:0]       c_inf;
  logic [LANES-1:0]       c_zexp;
  logic [LANES*WIDTH-1:0] res;
  logic [PC_W-1:0]        pop;
  logic [CNT_W:0]         sum;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign in_fire   = in_valid && s1_en;
  assign out_valid = s2_valid;

  always_comb begin
    c_neg  = '0;
    c_nan  = '0;
    c_inf  = '0;
    c_zexp = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [EXP_W-1:0] e;
      logic             m_nz;
      e         = in_data[i*WIDTH+MAN_W +: EXP_W];
      m_nz      = |in_data[i*WIDTH +: MAN_W];
      c_neg[i]  = in_data[i*WIDTH+WIDTH-1];
      c_nan[i]  = (&e) && m_nz;
      c_inf[i]  = (&e) && !m_nz;
      c_zexp[i] = (e == '0);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PC_W'(c_neg[i] && !c_nan[i]);
    end
  end

  // Clear happens before the add of a coincident beat
  always_comb begin
    sum = stat_clear ? '0 : {1'b0, stat_neg_count};
    if (in_fire) begin
      sum = sum + (CNT_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_neg_count <= '0;
    end else if (stat_clear || in_fire) begin
      stat_neg_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_RELU;
      s1_cap   <= '0;
      s1_neg   <= '0;
      s1_nan   <= '0;
      s1_inf   <= '0;
      s1_zexp  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
        s1_cap  <= in_cap;
        s1_neg  <= c_neg;
        s1_nan  <= c_nan;
        s1_inf  <= c_inf;
        s1_zexp <= c_zexp;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    relu_lane_fn #(
      .WIDTH      (WIDTH),
      .EXP_W      (EXP_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_fn (
      .x    (s1_data[g*WIDTH +: WIDTH]),
      .mode (s1_mode),
      .cap  (s1_cap),
      .neg  (s1_neg[g]),
      .nan  (s1_nan[g]),
      .inf  (s1_inf[g]),
      .zexp (s1_zexp[g]),
      .y    (res[g*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_relu_stream_unit.sv
// Directed self-checking bench for relu_stream_unit.
// A second instance with a 4-bit counter exercises saturation.
module tb_relu_stream_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [1:0]  in_mode = 2'b00;
  logic [15:0] in_cap = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        stat_clear = 1'b0;
  logic [31:0] stat_neg_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [63:0] out_data4;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  relu_stream_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_cap(in_cap),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .stat_clear(stat_clear), .stat_neg_count(stat_neg_count)
  );

  relu_stream_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .in_cap(in_cap),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4),
    .stat_clear(stat_clear), .stat_neg_count(cnt4)
  );

  function automatic logic [63:0] pack(
    logic [15:0] a0, logic [15:0] a1,
    logic [15:0] a2, logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Send one beat into an empty pipe; return out state after 1 and 2 edges
  task automatic run_beat(
    input  logic [63:0] d,
    input  logic [1:0]  m,
    input  logic [15:0] c,
    output logic        v_early,
    output logic        v,
    output logic [63:0] r);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    in_data  = d;
    in_mode  = m;
    in_cap   = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v_early  = out_valid;
    @(posedge clk); #1;
    v = out_valid;
    r = out_data;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests++;
    if (out_data !== 64'h0) begin
      fails++;
      $display("FAIL reset_out_data got %h want 0", out_data);
    end
    tests++;
    if (stat_neg_count !== 32'h0) begin
      fails++;
      $display("FAIL reset_count got %0d want 0", stat_neg_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_relu();
    logic ve, v;
    logic [63:0] r;
    run_beat(pack(16'h3C00, 16'hBC00, 16'h0000, 16'h7E00),
             2'b00, 16'h0, ve, v, r);
    tests++;
    if (ve !== 1'b0) begin
      fails++;
      $display("FAIL relu_latency_early got %b want 0", ve);
    end
    tests++;
    if (v !== 1'b1) begin
      fails++;
      $display("FAIL relu_valid got %b want 1", v);
    end
    tests++;
    if (r !== pack(16'h3C00, 16'h8000, 16'h0000, 16'h7E00)) begin
      fails++;
      $display("FAIL relu_data got %h want %h", r,
               pack(16'h3C00, 16'h8000, 16'h0000, 16'h7E00));
    end
    tests++;
    if (stat_neg_count !== 32'd1) begin
      fails++;
      $display("FAIL relu_count got %0d want 1", stat_neg_count);
    end
  endtask

  task automatic test_leaky();
    logic ve, v;
    logic [63:0] r;
    run_beat(pack(16'hBC00, 16'h8400, 16'hFC00, 16'h4000),
             2'b01, 16'h0, ve, v, r);
    tests++;
    if (!v || r !== pack(16'hB000, 16'h8000, 16'hFC00, 16'h4000)) begin
      fails++;
      $display("FAIL leaky_data got %h v=%b want %h", r, v,
               pack(16'hB000, 16'h8000, 16'hFC00, 16'h4000));
    end
    run_beat(pack(16'h9000, 16'h8C00, 16'hFE00, 16'h0001),
             2'b01, 16'h0, ve, v, r);
    tests++;
    if (!v || r !== pack(16'h8400, 16'h8000, 16'hFE00, 16'h0001)) begin
      fails++;
      $display("FAIL leaky_edge got %h v=%b want %h", r, v,
               pack(16'h8400, 16'h8000, 16'hFE00, 16'h0001));
    end
  endtask

  task automatic test_clamp();
    logic ve, v;
    logic [63:0] r;
    run_beat(pack(16'h4800, 16'h4400, 16'h7C00, 16'hC000),
             2'b10, 16'h4600, ve, v, r);
    tests++;
    if (!v || r !== pack(16'h4600, 16'h4400, 16'h4600, 16'h8000)) begin
      fails++;
      $display("FAIL clamp_data got %h v=%b want %h", r, v,
               pack(16'h4600, 16'h4400, 16'h4600, 16'h8000));
    end
    run_beat(pack(16'h3C00, 16'hBC00, 16'h7C00, 16'h7E01),
             2'b10, 16'hC000, ve, v, r);
    tests++;
    if (!v || r !== pack(16'h0000, 16'h0000, 16'h0000, 16'h7E01)) begin
      fails++;
      $display("FAIL clamp_negcap got %h v=%b want %h", r, v,
               pack(16'h0000, 16'h0000, 16'h0000, 16'h7E01));
    end
  endtask

  task automatic test_mode_alt();
    logic [63:0] got[$];
    logic [63:0] neg1 = 64'hBC00BC00BC00BC00;
    logic [63:0] nz   = 64'h8000800080008000;
    got = {};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        in_data  = neg1;
        in_mode  = (i % 2 == 0) ? 2'b00 : 2'b11;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) got.push_back(out_data);
    end
    in_valid = 1'b0;
    tests++;
    if (got.size() !== 4) begin
      fails++;
      $display("FAIL modealt_count got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== ((i % 2 == 0) ? nz : neg1)) begin
        fails++;
        $display("FAIL modealt_beat%0d got %h want %h", i, got[i],
                 (i % 2 == 0) ? nz : neg1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] src[6];
    logic [63:0] exp_d[6];
    logic        pat[3];
    logic        in_fire, out_fire, stalled;
    logic [63:0] held;
    int sent, got, cyc;
    src[0] = pack(16'h3C00, 16'hBC00, 16'h0001, 16'h8001);
    src[1] = pack(16'h4000, 16'hC000, 16'h7BFF, 16'hFBFF);
    src[2] = pack(16'h1234, 16'h9234, 16'h0000, 16'h8000);
    src[3] = pack(16'h7E00, 16'hFE00, 16'h7C00, 16'hFC00);
    src[4] = pack(16'h0100, 16'h8100, 16'h3555, 16'hB555);
    src[5] = pack(16'h5000, 16'hD000, 16'h6000, 16'hE000);
    exp_d[0] = pack(16'h3C00, 16'h8000, 16'h0001, 16'h8000);
    exp_d[1] = pack(16'h4000, 16'h8000, 16'h7BFF, 16'h8000);
    exp_d[2] = pack(16'h1234, 16'h8000, 16'h0000, 16'h8000);
    exp_d[3] = pack(16'h7E00, 16'hFE00, 16'h7C00, 16'h8000);
    exp_d[4] = pack(16'h0100, 16'h8000, 16'h3555, 16'h8000);
    exp_d[5] = pack(16'h5000, 16'h8000, 16'h6000, 16'h8000);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    sent = 0; got = 0; cyc = 0;
    stalled = 1'b0; held = '0;
    in_mode = 2'b00;
    while (got < 6 && cyc < 80) begin
      out_ready = pat[cyc % 3];
      in_valid  = (sent < 6);
      in_data   = (sent < 6) ? src[sent] : '0;
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (stalled) begin
        tests++;
        if (!out_valid || out_data !== held) begin
          fails++;
          $display("FAIL bp_hold got %h v=%b want %h", out_data,
                   out_valid, held);
        end
      end
      if (!in_ready) begin
        tests++;
        if (!(out_valid && !out_ready)) begin
          fails++;
          $display("FAIL bp_in_ready low with v=%b r=%b",
                   out_valid, out_ready);
        end
      end
      if (out_fire) begin
        tests++;
        if (out_data !== exp_d[got]) begin
          fails++;
          $display("FAIL bp_beat%0d got %h want %h", got,
                   out_data, exp_d[got]);
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      @(posedge clk); #1;
      if (in_fire) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (got !== 6) begin
      fails++;
      $display("FAIL bp_timeout got %0d beats want 6", got);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_extra_beat got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_stats();
    @(posedge clk); #1;
    stat_clear = 1'b1;
    in_valid   = 1'b1;
    in_mode    = 2'b00;
    in_data    = pack(16'hBC00, 16'h3C00, 16'h8000, 16'hFE00);
    @(posedge clk); #1;
    stat_clear = 1'b0;
    in_valid   = 1'b0;
    tests++;
    if (stat_neg_count !== 32'd2) begin
      fails++;
      $display("FAIL stat_clear_beat got %0d want 2", stat_neg_count);
    end
    tests++;
    if (cnt4 !== 4'd2) begin
      fails++;
      $display("FAIL stat_clear_beat4 got %0d want 2", cnt4);
    end
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hBC00BC00BC00BC00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (cnt4 !== 4'd15) begin
      fails++;
      $display("FAIL stat_saturate got %0d want 15", cnt4);
    end
    tests++;
    if (stat_neg_count !== 32'd16) begin
      fails++;
      $display("FAIL stat_wide got %0d want 16", stat_neg_count);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h3C003C003C003C00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre_valid got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || stat_neg_count !== 32'd0) begin
      fails++;
      $display("FAIL midrst_async got v=%b cnt=%0d want 0/0",
               out_valid, stat_neg_count);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_after got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_leaky();
    test_clamp();
    test_mode_alt();
    test_back_to_back();
    test_stats();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/relu_stream_unit.md
Name: relu_stream_unit

Overview:
- Multi-lane, pipelined activation unit for IEEE 754 values. It supersedes the single-value combinational ReLU.
- It takes LANES packed values per beat on a valid/ready stream. Each beat is processed in one of four modes: ReLU, leaky ReLU, clamped ReLU or bypass.
- Results leave on an output stream after a fixed 2-cycle latency. The block also counts negative lanes for activation-sparsity statistics.
- It sits between the MAC/accumulator output and the layer writeback buffer.

Parameters:
- WIDTH, 16, total bits per value; bit WIDTH-1 is the sign bit.
- EXP_W, 5, exponent field width; mantissa width is WIDTH-1-EXP_W.
- LANES, 4, values per beat.
- LEAK_SHIFT, 3, leaky-mode negative slope is 2^-LEAK_SHIFT, applied by exponent decrement; legal range 1..(2^EXP_W)-2.
- CNT_W, 32, width of the negative-lane statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- in_mode  in  2  mode for this beat: 00 relu, 01 leaky, 10 clamp, 11 bypass.
- in_cap  in  WIDTH  positive clamp ceiling for this beat (clamp mode only).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  LANES*WIDTH  results, same lane packing as in_data.
- stat_clear  in  1  synchronous clear of stat_neg_count.
- stat_neg_count  out  CNT_W  saturating count of negative non-NaN lanes accepted.

Behaviour:
- Reset values (async, rst_n=0): out_valid=0, out_data=0, stat_neg_count=0, both pipeline valid flags 0. in_ready is 1 once reset is released.
- Pipeline structure:
  - Stage 1 registers in_data, in_mode and in_cap, plus per-lane class flags: neg, nan, inf, zero exponent.
  - Stage 2 registers the results.
  - Latency is exactly 2 cycles from the accept edge to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Handshake:
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en. This is a combinational path from out_ready and is allowed.
  - No beat is dropped or duplicated.
  - out_data is stable while out_valid && !out_ready.
- Mode and cap are sampled per beat, so a mode change between consecutive beats takes effect exactly on the next beat.
- Per-lane function (x = lane value, s = sign, e = exponent, m = mantissa):
  - NaN (e all ones, m≠0): passes unchanged in every mode.
  - relu: s=0 → x. s=1 → {1'b1, zeros} (negative zero; preserves the existing ReLU encoding).
  - leaky: s=0 → x. s=1 and e>LEAK_SHIFT → {1, e-LEAK_SHIFT, m}. s=1 and e≤LEAK_SHIFT (including subnormals) → {1'b1, zeros}. -Inf → -Inf.
  - clamp: apply relu first. Then, if the result is positive and its magnitude bits [WIDTH-2:0] exceed in_cap[WIDTH-2:0] (unsigned compare), output in_cap. +Inf → in_cap. A negative-signed in_cap is treated as +0 ceiling, so all outputs become +0.
  - bypass: x unchanged.
- Statistics:
  - On each accepted beat (stage-1 load), stat_neg_count += popcount of lanes with s=1 and not NaN. -0 counts as negative.
  - The counter saturates at all ones.
  - If stat_clear and a beat are accepted in the same cycle, the counter loads that beat's popcount (clear first, then add).
- Reset mid-operation: in-flight beats are discarded and out_valid drops asynchronously. No partial output is presented after reset release.

Decomposition:
- Shared package holds:
  - the mode encoding constants: MODE_RELU=2'b00, MODE_LEAKY=2'b01, MODE_CLAMP=2'b10, MODE_BYPASS=2'b11;
  - half-precision field constants.
- One natural sub-module, relu_lane_fn: the combinational per-lane function (x, mode, cap → y), instantiated LANES times inside stage 2.
- Pipeline control and the counter stay in the top.

Test Plan:
- relu, LANES=4, in_data lanes {0x3C00, 0xBC00, 0x0000, 0x7E00} with out_ready=1 → two cycles later out_data {0x3C00, 0x8000, 0x0000, 0x7E00}; stat_neg_count=1.
- leaky, lanes {0xBC00, 0x8400, 0xFC00, 0x4000} → {0xB000, 0x8000, 0xFC00, 0x4000}.
- clamp, cap=0x4600 (6.0), lanes {0x4800, 0x4400, 0x7C00, 0xC000} → {0x4600, 0x4400, 0x4600, 0x8000}.
- Back-pressure: stream 6 beats with out_ready toggling 1,0,0,1,… → output order and data match a reference model with no loss or duplication; out_data holds while stalled; in_ready drops only while both stages are full.
- Mode alternation relu/bypass on consecutive beats of 0xBC00 → outputs 0x8000, 0xBC00, 0x8000, 0xBC00.
- Statistics:
  - CNT_W=4: feed 4 beats of 4 negatives → count saturates at 15.
  - stat_clear coincident with a beat of 2 negatives → count=2.
  - Assert rst_n low mid-stream → out_valid=0 and count=0 immediately.
